// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer: FIFO of pending register writes drained one per cycle, with newest-value bypass lookup
module regfile_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       drain_en,
    output logic                       wr_ld,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    input  logic [ADDR_W-1:0]          lk_addr,
    output logic                       lk_hit,
    output logic [DATA_W-1:0]          lk_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [PW-1:0]     wp, rp, idx;
    logic              push, pop;
    assign in_ready = count != CW'(DEPTH);
    assign push     = in_valid && in_ready;
    assign pop      = drain_en && count != '0;
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wp] <= in_addr;
            mem_data[wp] <= in_data;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            vld     <= '0;
            wr_ld   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (push) begin
                vld[wp] <= 1'b1;
                wp      <= wp + 1'b1;
            end
            if (pop) begin
                vld[rp] <= 1'b0;
                rp      <= rp + 1'b1;
                wr_addr <= mem_addr[rp];
                wr_data <= mem_data[rp];
            end
            wr_ld <= pop;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    // Walk oldest to youngest so the youngest match wins; the port value is the oldest candidate.
    always_comb begin
        lk_hit  = wr_ld && wr_addr == lk_addr;
        lk_data = lk_hit ? wr_data : '0;
        idx     = rp;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rp + PW'(i);
            if (vld[idx] && mem_addr[idx] == lk_addr) begin
                lk_hit  = 1'b1;
                lk_data = mem_data[idx];
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb_regfile_write_buffer: scoreboard bench for regfile_write_buffer
module tb_regfile_write_buffer;
    localparam int DEPTH = 4;
    typedef struct packed {logic [3:0] a; logic [31:0] d;} wr_t;
    logic        clk = 0, reset = 1;
    logic        in_valid = 0, in_ready, drain_en = 0, wr_ld, lk_hit;
    logic [3:0]  in_addr = 0, wr_addr, lk_addr = 0;
    logic [31:0] in_data = 0, wr_data, lk_data;
    logic [2:0]  count;
    wr_t         sbq[$];
    wr_t         fly;
    bit          fly_v;
    int          nchk = 0, nerr = 0;

    regfile_write_buffer #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .drain_en(drain_en),
        .wr_ld(wr_ld), .wr_addr(wr_addr), .wr_data(wr_data),
        .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        check("count", 32'(count), 32'(sbq.size()));
        check("in_ready", 32'(in_ready), 32'(sbq.size() != DEPTH));
    endtask

    task automatic tick();
        bit p, q;
        wr_t e;
        p = in_valid && sbq.size() != DEPTH;
        q = drain_en && sbq.size() != 0;
        e = '0;
        if (q) e = sbq.pop_front();
        if (p) sbq.push_back({in_addr, in_data});
        @(posedge clk);
        #1;
        check("wr_ld", 32'(wr_ld), 32'(q));
        if (q) begin
            check("wr_addr", 32'(wr_addr), 32'(e.a));
            check("wr_data", wr_data, e.d);
            fly = e;
        end
        fly_v = q;
        check_state();
    endtask

    task automatic lookup(input logic [3:0] a);
        bit h;
        logic [31:0] d;
        lk_addr = a;
        #1;
        h = fly_v && fly.a == a;
        d = h ? fly.d : 32'h0;
        foreach (sbq[i]) if (sbq[i].a == a) begin h = 1; d = sbq[i].d; end
        check("lk_hit", 32'(lk_hit), 32'(h));
        check("lk_data", lk_data, d);
    endtask

    task automatic push(input logic [3:0] a, input logic [31:0] d);
        in_valid = 1; in_addr = a; in_data = d;
        tick();
        in_valid = 0;
    endtask

    initial begin
        fly = '0; fly_v = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        check("rst_wr_ld", 32'(wr_ld), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", wr_data, 0);
        check_state();
        // single write
        drain_en = 1;
        push(4'd5, 32'hFFFFFF00);
        tick();
        check("single_addr", 32'(wr_addr), 32'd5);
        tick();
        // fill and stall
        drain_en = 0;
        for (int i = 1; i <= 4; i++) push(4'(i), 32'(i * 'h11));
        check("full_ready", 32'(in_ready), 0);
        push(4'd6, 32'h66);
        lookup(4'd3);
        lookup(4'd6);
        drain_en = 1;
        repeat (5) tick();
        // bypass priority, in-flight and miss
        drain_en = 0;
        push(4'd7, 32'hA);
        push(4'd7, 32'hB);
        lookup(4'd7);
        drain_en = 1;
        tick();
        lookup(4'd7);
        tick();
        drain_en = 0;
        lookup(4'd7);
        check("fly_B", lk_data, 32'hB);
        lookup(4'd9);
        in_valid = 1; in_addr = 4'd9; in_data = 32'h99;
        lookup(4'd9);
        check("offer_miss", 32'(lk_hit), 0);
        tick();
        in_valid = 0;
        drain_en = 1;
        repeat (2) tick();
        // simultaneous push/pop then wrap with continuous drain
        drain_en = 0;
        push(4'd1, 32'h101);
        push(4'd2, 32'h102);
        drain_en = 1;
        push(4'd3, 32'h103);
        check("pushpop_cnt", 32'(count), 32'd2);
        for (int i = 0; i < 8; i++) begin
            push(4'(i), $urandom);
            lookup(4'(i));
        end
        repeat (4) tick();
        // address 0 plus reset mid-operation
        drain_en = 0;
        push(4'd0, 32'hC0);
        push(4'd2, 32'hC2);
        lookup(4'd0);
        #2 reset = 1;
        #1;
        sbq.delete();
        fly_v = 0;
        check("mid_wr_ld", 32'(wr_ld), 0);
        check("mid_wr_addr", 32'(wr_addr), 0);
        check("mid_wr_data", wr_data, 0);
        check_state();
        @(posedge clk);
        #1 reset = 0;
        drain_en = 1;
        repeat (3) tick();
        lookup(4'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
